ecc_scrubber: RTL and testbench

// Background scrubber between an ECC-protected SRAM bank and its interconnect

---
 rtl/ecc_scrubber.sv | 118 +++++++++++
 tb/tb_ecc_scrubber.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrubber sharing one ECC-protected SRAM bank port with the interconnect.
// Latency: 2 cycles per clean or uncorrectable word, 3 per corrected word (plus any stall cycles).
// Backpressure: the interconnect always owns the bank; the scrubber waits in IDLE/WRITE for a free cycle.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   scrub_trigger_i            level request to scrub one word (held high = continuous)
//   bit_corrected_o            pulse: corrective write issued this cycle
//   uncorrectable_o            pulse: double error detected, word left untouched
//   intc_*                     interconnect port (pass-through to the bank when intc_req_i=1)
//   bank_*                     SRAM bank port (read data valid one cycle after a read request)
//   dec_cw_o/dec_data_i/dec_err_i  external ECC decoder (combinational)
//   enc_data_o/enc_cw_i        external ECC encoder (combinational)
module ecc_scrubber #(
  parameter int BankSize  = 256,
  parameter int DataWidth = 32,
  localparam int AddrWidth = $clog2(BankSize),
  // SECDED codeword: Hamming parity bits plus one overall parity bit (39 for 32 data bits)
  localparam int CwWidth   = DataWidth + $clog2(DataWidth + $clog2(DataWidth) + 1) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 scrub_trigger_i,
  output logic                 bit_corrected_o,
  output logic                 uncorrectable_o,
  input  logic                 intc_req_i,
  input  logic                 intc_we_i,
  input  logic [AddrWidth-1:0] intc_add_i,
  input  logic [CwWidth-1:0]   intc_wdata_i,
  output logic [CwWidth-1:0]   intc_rdata_o,
  output logic                 bank_req_o,
  output logic                 bank_we_o,
  output logic [AddrWidth-1:0] bank_add_o,
  output logic [CwWidth-1:0]   bank_wdata_o,
  input  logic [CwWidth-1:0]   bank_rdata_i,
  output logic [CwWidth-1:0]   dec_cw_o,
  input  logic [DataWidth-1:0] dec_data_i,
  input  logic [1:0]           dec_err_i,
  output logic [DataWidth-1:0] enc_data_o,
  input  logic [CwWidth-1:0]   enc_cw_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t               state;
  logic [AddrWidth-1:0] scrub_addr;
  logic [AddrWidth-1:0] addr_next;
  logic [CwWidth-1:0]   cw_q;
  logic                 scrub_rd;
  logic                 scrub_wr;
  logic                 intc_overwrite;

  // Explicit wrap so non-power-of-two banks also roll over at BankSize-1
  assign addr_next = (scrub_addr == AddrWidth'(BankSize - 1)) ? '0 : scrub_addr + AddrWidth'(1);

  assign scrub_rd = (state == IDLE)  && scrub_trigger_i && !intc_req_i;
  assign scrub_wr = (state == WRITE) && !intc_req_i;

  // An interconnect write to the word being corrected makes the stored codeword stale
  assign intc_overwrite = intc_req_i && intc_we_i && (intc_add_i == scrub_addr);

  // Bank port: interconnect has unconditional priority
  assign bank_req_o   = intc_req_i ? 1'b1         : (scrub_rd || scrub_wr);
  assign bank_we_o    = intc_req_i ? intc_we_i    : scrub_wr;
  assign bank_add_o   = intc_req_i ? intc_add_i   : scrub_addr;
  assign bank_wdata_o = intc_req_i ? intc_wdata_i : cw_q;

  assign intc_rdata_o = bank_rdata_i;
  assign dec_cw_o     = bank_rdata_i;
  assign enc_data_o   = dec_data_i;

  // Read data belongs to the scrubber in READ even if the interconnect grabs the port this cycle
  assign uncorrectable_o = (state == READ) && dec_err_i[1];
  assign bit_corrected_o = scrub_wr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      scrub_addr <= '0;
      cw_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scrub_rd) begin
            state <= READ;
          end
        end
        READ: begin
          if (dec_err_i[1]) begin
            scrub_addr <= addr_next;
            state      <= IDLE;
          end else if (dec_err_i[0]) begin
            cw_q  <= enc_cw_i;
            state <= WRITE;
          end else begin
            scrub_addr <= addr_next;
            state      <= IDLE;
          end
        end
        WRITE: begin
          // Either our write goes out, or newer interconnect data replaces it; otherwise stall
          if (scrub_wr || intc_overwrite) begin
            scrub_addr <= addr_next;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_scrubber.sv
module tb_ecc_scrubber;

  localparam int BANK = 256;
  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int CW   = 39;

  localparam int EV_RD  = 1;  // scrubber read
  localparam int EV_WR  = 2;  // scrubber write with bit_corrected pulse
  localparam int EV_UNC = 3;  // uncorrectable pulse
  localparam int EV_WNP = 4;  // scrubber write without pulse
  localparam int EV_PNW = 5;  // bit_corrected pulse without a scrubber write

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trig;
  logic          bit_corrected;
  logic          uncorrectable;
  logic          intc_req;
  logic          intc_we;
  logic [AW-1:0] intc_add;
  logic [CW-1:0] intc_wdata;
  logic [CW-1:0] intc_rdata;
  logic          bank_req;
  logic          bank_we;
  logic [AW-1:0] bank_add;
  logic [CW-1:0] bank_wdata;
  logic [CW-1:0] bank_rdata;
  logic [CW-1:0] dec_cw;
  logic [DW-1:0] dec_data;
  logic [1:0]    dec_err;
  logic [DW-1:0] enc_data;
  logic [CW-1:0] enc_cw;

  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [CW-1:0] bd_dat;

  logic [CW-1:0] mem [BANK];
  int            ev_q[$];
  int            last_rd;
  int            checks = 0;
  int            errors = 0;
  int            ptr    = 0;

  always #5 clk = ~clk;

  ecc_scrubber dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .scrub_trigger_i (trig),
    .bit_corrected_o (bit_corrected),
    .uncorrectable_o (uncorrectable),
    .intc_req_i      (intc_req),
    .intc_we_i       (intc_we),
    .intc_add_i      (intc_add),
    .intc_wdata_i    (intc_wdata),
    .intc_rdata_o    (intc_rdata),
    .bank_req_o      (bank_req),
    .bank_we_o       (bank_we),
    .bank_add_o      (bank_add),
    .bank_wdata_o    (bank_wdata),
    .bank_rdata_i    (bank_rdata),
    .dec_cw_o        (dec_cw),
    .dec_data_i      (dec_data),
    .dec_err_i       (dec_err),
    .enc_data_o      (enc_data),
    .enc_cw_i        (enc_cw)
  );

  // Stand-in ECC: top two codeword bits carry the error class, low bits the payload.
  assign dec_data = dec_cw[DW-1:0];
  assign dec_err  = dec_cw[CW-1:CW-2];
  assign enc_cw   = {2'b00, 5'b10101, enc_data};

  function automatic logic [CW-1:0] mk_cw(input logic [1:0] tag, input logic [DW-1:0] d);
    return {tag, 5'b00000, d};
  endfunction

  function automatic logic [CW-1:0] enc_of(input logic [DW-1:0] d);
    return {2'b00, 5'b10101, d};
  endfunction

  function automatic int word_cycles(input logic [CW-1:0] cw);
    return (cw[CW-1:CW-2] == 2'b01) ? 3 : 2;
  endfunction

  // SRAM bank model with a backdoor load port
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_dat;
    else if (bank_req && bank_we) mem[bank_add] <= bank_wdata;
    if (bank_req && !bank_we) bank_rdata <= mem[bank_add];
  end

  // Event log of scrubber-visible activity
  always @(negedge clk) begin
    if (!intc_req && bank_req && !bank_we) begin
      ev_q.push_back((EV_RD << 16) | int'(bank_add));
      last_rd <= int'(bank_add);
    end
    if (!intc_req && bank_req && bank_we)
      ev_q.push_back(((bit_corrected ? EV_WR : EV_WNP) << 16) | int'(bank_add));
    if (bit_corrected && (intc_req || !bank_req || !bank_we))
      ev_q.push_back(EV_PNW << 16);
    if (uncorrectable)
      ev_q.push_back((EV_UNC << 16) | last_rd);
  end

  task automatic bd_write(input int a, input logic [CW-1:0] cw);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = AW'(a); bd_dat = cw;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic run_trigger(input int s);
    @(posedge clk); #1;
    trig = 1'b1;
    repeat (s) @(posedge clk);
    #1;
    trig = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic advance(input int target);
    int s;
    s = 0;
    for (int a = ptr; a != target; a = (a + 1) % BANK) s += word_cycles(mem[a]);
    if (s > 0) run_trigger(s);
    ptr = target;
  endtask

  task automatic test_reset();
    logic [CW-1:0] r;
    rst_n = 1'b0; trig = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
    intc_req = 1'b0; intc_we = 1'b0; intc_add = '0; intc_wdata = '0;
    for (int a = 0; a < BANK; a++) bd_write(a, mk_cw(2'b00, $urandom));
    @(negedge clk);
    checks++;
    if (bank_req !== 1'b0 || bit_corrected !== 1'b0 || uncorrectable !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle req=%b bc=%b unc=%b want 0 0 0", bank_req, bit_corrected, uncorrectable);
    end
    r = mk_cw(2'b00, $urandom);
    @(posedge clk); #1;
    intc_req = 1'b1; intc_we = 1'b1; intc_add = 8'h42; intc_wdata = r;
    @(negedge clk);
    checks++;
    if (bank_req !== 1'b1 || bank_we !== 1'b1 || bank_add !== 8'h42 || bank_wdata !== r) begin
      errors++;
      $display("FAIL reset_passthru req=%b we=%b add=%h wd=%h want 1 1 42 %h", bank_req, bank_we, bank_add, bank_wdata, r);
    end
    @(posedge clk); #1;
    intc_we = 1'b0;
    @(posedge clk); #1;
    intc_req = 1'b0;
    @(negedge clk);
    checks++;
    if (intc_rdata !== r || dec_cw !== r || enc_data !== r[DW-1:0]) begin
      errors++;
      $display("FAIL rdata_passthru rdata=%h dec_cw=%h enc=%h want %h", intc_rdata, dec_cw, enc_data, r);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bank_req !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_req got %b want 0", bank_req);
    end
    ptr = 0;
  endtask

  task automatic test_clean_hold();
    int base;
    int exp_q[$];
    base = ev_q.size();
    run_trigger(4);
    exp_q = '{(EV_RD << 16) | 0, (EV_RD << 16) | 1};
    checks++;
    if (ev_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL clean_ev_count got %0d want %0d", ev_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL clean_ev[%0d] got %h want %h", i, ev_q[base + i], exp_q[i]);
      end
    end
    ptr = 2;
  endtask

  task automatic test_abort();
    int base;
    logic [CW-1:0] r;
    advance(3);
    bd_write(3, mk_cw(2'b01, $urandom));
    r = mk_cw(2'b00, $urandom);
    base = ev_q.size();
    @(posedge clk); #1; trig = 1'b1;
    @(posedge clk); #1; trig = 1'b0;
    @(posedge clk); #1;
    intc_req = 1'b1; intc_we = 1'b1; intc_add = 8'd3; intc_wdata = r;
    @(negedge clk);
    checks++;
    if (bank_we !== 1'b1 || bank_add !== 8'd3 || bank_wdata !== r || bit_corrected !== 1'b0) begin
      errors++;
      $display("FAIL abort_bus we=%b add=%h wd=%h bc=%b want 1 03 %h 0", bank_we, bank_add, bank_wdata, bit_corrected, r);
    end
    @(posedge clk); #1;
    intc_req = 1'b0; intc_we = 1'b0;
    repeat (4) @(posedge clk);
    checks++;
    if (ev_q.size() - base != 1 || ev_q[base] !== ((EV_RD << 16) | 3)) begin
      errors++;
      $display("FAIL abort_events got %0d events first %h want 1 event %h", ev_q.size() - base,
               (ev_q.size() > base) ? ev_q[base] : -1, (EV_RD << 16) | 3);
    end
    checks++;
    if (mem[3] !== r) begin
      errors++;
      $display("FAIL abort_mem got %h want %h", mem[3], r);
    end
    ptr = 4;
  endtask

  task automatic test_stall();
    int base;
    logic [DW-1:0] d;
    d = $urandom;
    bd_write(4, mk_cw(2'b01, d));
    base = ev_q.size();
    @(posedge clk); #1; trig = 1'b1;
    @(posedge clk); #1; trig = 1'b0;
    @(posedge clk); #1;
    intc_req = 1'b1; intc_we = 1'b0; intc_add = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bank_we !== 1'b0 || bank_add !== 8'd9 || bit_corrected !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d we=%b add=%h bc=%b want 0 09 0", i, bank_we, bank_add, bit_corrected);
      end
      @(posedge clk); #1;
      if (i == 4) intc_req = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bank_req !== 1'b1 || bank_we !== 1'b1 || bank_add !== 8'd4 || bank_wdata !== enc_of(d) || bit_corrected !== 1'b1) begin
      errors++;
      $display("FAIL stall_release req=%b we=%b add=%h wd=%h bc=%b want 1 1 04 %h 1",
               bank_req, bank_we, bank_add, bank_wdata, bit_corrected, enc_of(d));
    end
    repeat (4) @(posedge clk);
    checks++;
    if (ev_q.size() - base != 2 || ev_q[base + 1] !== ((EV_WR << 16) | 4)) begin
      errors++;
      $display("FAIL stall_events got %0d events want 2 ending %h", ev_q.size() - base, (EV_WR << 16) | 4);
    end
    checks++;
    if (mem[4] !== enc_of(d)) begin
      errors++;
      $display("FAIL stall_mem got %h want %h", mem[4], enc_of(d));
    end
    ptr = 5;
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = $urandom;
    bd_write(5, mk_cw(2'b01, d));
    @(posedge clk); #1; trig = 1'b1;
    @(negedge clk);
    checks++;
    if (bank_req !== 1'b1 || bank_we !== 1'b0 || bank_add !== 8'd5) begin
      errors++;
      $display("FAIL single_read req=%b we=%b add=%h want 1 0 05", bank_req, bank_we, bank_add);
    end
    @(posedge clk); #1; trig = 1'b0;
    @(negedge clk);
    checks++;
    if (bank_req !== 1'b0 || bit_corrected !== 1'b0 || uncorrectable !== 1'b0) begin
      errors++;
      $display("FAIL single_decode req=%b bc=%b unc=%b want 0 0 0", bank_req, bit_corrected, uncorrectable);
    end
    @(negedge clk);
    checks++;
    if (bank_we !== 1'b1 || bank_add !== 8'd5 || bank_wdata !== enc_of(d) || bit_corrected !== 1'b1) begin
      errors++;
      $display("FAIL single_write we=%b add=%h wd=%h bc=%b want 1 05 %h 1", bank_we, bank_add, bank_wdata, bit_corrected, enc_of(d));
    end
    @(negedge clk);
    checks++;
    if (bit_corrected !== 1'b0 || bank_req !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width bc=%b req=%b want 0 0", bit_corrected, bank_req);
    end
    repeat (3) @(posedge clk);
    ptr = 6;
  endtask

  task automatic test_double();
    int base;
    logic [CW-1:0] cw;
    advance(7);
    cw = mk_cw(2'b10, $urandom);
    bd_write(7, cw);
    base = ev_q.size();
    run_trigger(2);
    checks++;
    if (ev_q.size() - base != 2 || ev_q[base] !== ((EV_RD << 16) | 7) || ev_q[base + 1] !== ((EV_UNC << 16) | 7)) begin
      errors++;
      $display("FAIL double_events got %0d events want %h %h", ev_q.size() - base, (EV_RD << 16) | 7, (EV_UNC << 16) | 7);
    end
    checks++;
    if (mem[7] !== cw) begin
      errors++;
      $display("FAIL double_mem got %h want %h", mem[7], cw);
    end
    ptr = 8;
  endtask

  task automatic test_random();
    int base, s, a;
    int exp_q[$];
    logic [CW-1:0] exp_mem [24];
    logic [1:0] tag;
    logic [DW-1:0] d;
    s = 0;
    for (int i = 0; i < 24; i++) begin
      a = (ptr + i) % BANK;
      tag = 2'($urandom_range(0, 3));
      d = $urandom;
      bd_write(a, mk_cw(tag, d));
      exp_q.push_back((EV_RD << 16) | a);
      if (tag == 2'b01) begin
        exp_q.push_back((EV_WR << 16) | a);
        exp_mem[i] = enc_of(d);
        s += 3;
      end else begin
        if (tag[1]) exp_q.push_back((EV_UNC << 16) | a);
        exp_mem[i] = mk_cw(tag, d);
        s += 2;
      end
    end
    base = ev_q.size();
    run_trigger(s);
    checks++;
    if (ev_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL rand_ev_count got %0d want %0d", ev_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_ev[%0d] got %h want %h", i, ev_q[base + i], exp_q[i]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (mem[(ptr + i) % BANK] !== exp_mem[i]) begin
        errors++;
        $display("FAIL rand_mem[%0d] got %h want %h", (ptr + i) % BANK, mem[(ptr + i) % BANK], exp_mem[i]);
      end
    end
    ptr = (ptr + 24) % BANK;
  endtask

  task automatic test_wrap();
    int base;
    advance(BANK - 1);
    bd_write(BANK - 1, mk_cw(2'b00, $urandom));
    bd_write(0, mk_cw(2'b00, $urandom));
    base = ev_q.size();
    run_trigger(4);
    checks++;
    if (ev_q.size() - base != 2 || ev_q[base] !== ((EV_RD << 16) | (BANK - 1)) || ev_q[base + 1] !== ((EV_RD << 16) | 0)) begin
      errors++;
      $display("FAIL wrap_events got %0d events want %h %h", ev_q.size() - base, (EV_RD << 16) | (BANK - 1), (EV_RD << 16) | 0);
    end
    ptr = 1;
  endtask

  task automatic test_reset_in_write();
    int base;
    logic [CW-1:0] cw;
    cw = mk_cw(2'b01, $urandom);
    bd_write(1, cw);
    base = ev_q.size();
    @(posedge clk); #1; trig = 1'b1;
    @(posedge clk); #1; trig = 1'b0;
    @(posedge clk); #1;
    intc_req = 1'b1; intc_we = 1'b0; intc_add = 8'd9;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bank_req !== 1'b1 || bank_we !== 1'b0 || bit_corrected !== 1'b0 || uncorrectable !== 1'b0) begin
      errors++;
      $display("FAIL rst_write_hold req=%b we=%b bc=%b unc=%b want 1 0 0 0", bank_req, bank_we, bit_corrected, uncorrectable);
    end
    @(posedge clk); #1;
    intc_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bank_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_write_req got %b want 0", bank_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    checks++;
    if (ev_q.size() - base != 1 || mem[1] !== cw) begin
      errors++;
      $display("FAIL rst_write_dropped events=%0d mem1=%h want 1 %h", ev_q.size() - base, mem[1], cw);
    end
    base = ev_q.size();
    run_trigger(2);
    checks++;
    if (ev_q.size() - base != 1 || ev_q[base] !== ((EV_RD << 16) | 0)) begin
      errors++;
      $display("FAIL rst_addr_zero got %0d events first %h want %h", ev_q.size() - base,
               (ev_q.size() > base) ? ev_q[base] : -1, (EV_RD << 16) | 0);
    end
    ptr = 1;
  endtask

  initial begin
    test_reset();
    test_clean_hold();
    test_abort();
    test_stall();
    test_single();
    test_double();
    test_random();
    test_wrap();
    test_reset_in_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
